// File: rtl/wavegen_ctrl.sv
// wavegen_ctrl: phase-accumulator waveform sequencer with a one-deep config slot and a valid/ready sample output.
// The optional 8-bit saturating discard counter o_overrun_cnt is built only when WAVEGEN_OVERRUN_CNT_EN is defined.
module wavegen_ctrl #(
    parameter int PHASE_W = 16,
    parameter int DIV_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [DIV_W-1:0]     i_rate_div,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [PHASE_W-1:0]   i_cfg_step,
    input  logic [3:0]           i_cfg_sel,
    input  logic [1:0]           i_cfg_wave,
    output logic [9:0]           o_addr,
    output logic [3:0]           o_sel,
    output logic [1:0]           o_wave,
    input  logic signed [15:0]   i_gen_data,
    output logic signed [15:0]   o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_wrap,
`ifdef WAVEGEN_OVERRUN_CNT_EN
    output logic [7:0]           o_overrun_cnt,
`endif
    output logic                 o_overrun
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [DIV_W-1:0] cnt;
    logic [PHASE_W-1:0] phase, step, sum, pend_step;
    logic [3:0] pend_sel;
    logic [1:0] pend_wave;
    logic pend_valid, run, tick, carry, accept, apply, take;

    assign o_cfg_ready = !pend_valid;
    assign o_addr = phase[PHASE_W-1 -: 10];

    // next state, tick strobe, phase sum and config/sample decisions
    always_comb begin
        state_nx = i_en ? RUN : IDLE;
        run = (state == RUN) && i_en;
        tick = run && (cnt == i_rate_div);
        {carry, sum} = {1'b0, phase} + {1'b0, step};
        accept = i_cfg_valid && !pend_valid;
        apply = pend_valid && ((state == IDLE) || (tick && carry));
        take = tick && (!o_valid || i_ready);
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    end

    // tick counter, phase accumulator and wrap pulse; leaving RUN zeroes both
    always_ff @(posedge i_clk) begin
        if (i_rst || !run) begin
            cnt <= '0;
            phase <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) phase <= sum;
        end
        o_wrap <= !i_rst && tick && carry;
    end

    // pending slot capture and application on idle or phase wrap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_valid <= 1'b0;
            pend_step <= '0;
            pend_sel <= '0;
            pend_wave <= '0;
            step <= '0;
            o_sel <= '0;
            o_wave <= '0;
        end else begin
            if (accept) begin
                pend_valid <= 1'b1;
                pend_step <= i_cfg_step;
                pend_sel <= (i_cfg_sel > 4'd10) ? 4'd10 : i_cfg_sel;
                pend_wave <= i_cfg_wave;
            end
            if (apply) begin
                pend_valid <= 1'b0;
                step <= pend_step;
                o_sel <= pend_sel;
                o_wave <= pend_wave;
            end
        end
    end

    // sample register: load on tick when free, else drop and flag overrun
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= '0;
            o_valid <= 1'b0;
            o_overrun <= 1'b0;
        end else if (take) begin
            o_data <= i_gen_data;
            o_valid <= 1'b1;
        end else if (tick) begin
            o_overrun <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef WAVEGEN_OVERRUN_CNT_EN
    // saturating count of discarded samples
    always_ff @(posedge i_clk) begin
        if (i_rst) o_overrun_cnt <= '0;
        else if (tick && !take && o_overrun_cnt != 8'hff) o_overrun_cnt <= o_overrun_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_wavegen_ctrl.sv
// tb_wavegen_ctrl: table-driven and sequence checks of wavegen_ctrl with a sample scoreboard.
module tb_wavegen_ctrl;
    logic i_clk = 1'b0;
    logic i_rst, i_en, i_cfg_valid, o_cfg_ready, o_valid, i_ready, o_wrap, o_overrun;
    logic [15:0] i_rate_div, i_cfg_step;
    logic [3:0] i_cfg_sel, o_sel;
    logic [1:0] i_cfg_wave, o_wave;
    logic [9:0] o_addr;
    logic signed [15:0] i_gen_data, o_data;
`ifdef WAVEGEN_OVERRUN_CNT_EN
    logic [7:0] o_overrun_cnt;
`endif

    typedef struct {
        logic [15:0] step;
        logic [3:0] sel;
        logic [1:0] wave;
        logic [15:0] div;
        int ticks;
        logic [3:0] exp_sel;
        int exp_wraps;
        logic [9:0] exp_addr;
    } row_t;

    row_t rows[4];
    logic [15:0] sb[$];
    int n_vec = 0, n_err = 0;
    int wraps, vcyc;

    always #5 i_clk = ~i_clk;

    // generator stand-in: response encodes the request so each sample is traceable
    always_comb i_gen_data = {o_wave, o_sel, o_addr};

    wavegen_ctrl #(.PHASE_W(16), .DIV_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_rate_div(i_rate_div),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_step(i_cfg_step),
        .i_cfg_sel(i_cfg_sel), .i_cfg_wave(i_cfg_wave), .o_addr(o_addr), .o_sel(o_sel),
        .o_wave(o_wave), .i_gen_data(i_gen_data), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_wrap(o_wrap),
`ifdef WAVEGEN_OVERRUN_CNT_EN
        .o_overrun_cnt(o_overrun_cnt),
`endif
        .o_overrun(o_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cfg(input logic [15:0] st, input logic [3:0] s, input logic [1:0] w);
        i_cfg_valid = 1'b1;
        i_cfg_step = st;
        i_cfg_sel = s;
        i_cfg_wave = w;
        clk1();
        i_cfg_valid = 1'b0;
        clk1();
    endtask

    function automatic logic [15:0] smp(input logic [1:0] w, input logic [3:0] s, input int k, input logic [15:0] st);
        logic [31:0] p;
        p = k * st;
        return {w, s, p[15:6]};
    endfunction

    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra: got 0x%0h expected no sample", $unsigned(o_data));
            end else begin
                chk("sample", $unsigned(o_data), sb.pop_front());
            end
        end
    end

    initial begin
        rows[0] = '{16'h0400, 4'd5, 2'd0, 16'd0, 130, 4'd5, 2, 10'd32};
        rows[1] = '{16'h1000, 4'd12, 2'd2, 16'd3, 20, 4'd10, 1, 10'd256};
        rows[2] = '{16'h3333, 4'd10, 2'd3, 16'd1, 9, 4'd10, 1, 10'd819};
        rows[3] = '{16'hffff, 4'd0, 2'd1, 16'd2, 5, 4'd0, 4, 10'd1023};

        i_rst = 1'b1; i_en = 1'b1; i_rate_div = '0; i_ready = 1'b0;
        i_cfg_valid = 1'b1; i_cfg_step = 16'h1234; i_cfg_sel = 4'd3; i_cfg_wave = 2'd2;
        clk1();
        clk1();
        chk("rst_addr", o_addr, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_wave", o_wave, 0);
        chk("rst_data", $unsigned(o_data), 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_wrap", o_wrap, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_cfg_ready", o_cfg_ready, 1);
        i_rst = 1'b0; i_en = 1'b0; i_cfg_valid = 1'b0;
        clk1();
        chk("post_rst_sel", o_sel, 0);

        for (int r = 0; r < 4; r++) begin
            cfg(rows[r].step, rows[r].sel, rows[r].wave);
            chk("row_sel", o_sel, rows[r].exp_sel);
            chk("row_wave", o_wave, rows[r].wave);
            for (int k = 0; k < rows[r].ticks; k++) sb.push_back(smp(rows[r].wave, rows[r].exp_sel, k, rows[r].step));
            i_rate_div = rows[r].div; i_ready = 1'b1; i_en = 1'b1;
            wraps = 0; vcyc = 0;
            repeat (1 + rows[r].ticks * (int'(rows[r].div) + 1)) begin
                clk1();
                wraps += int'(o_wrap);
                vcyc += int'(o_valid);
            end
            chk("row_addr", o_addr, rows[r].exp_addr);
            chk("row_wraps", wraps, rows[r].exp_wraps);
            chk("row_valid_cycles", vcyc, rows[r].ticks);
            i_en = 1'b0;
            clk1();
            chk("row_stop_addr", o_addr, 0);
            clk1();
            chk("row_idle_valid", o_valid, 0);
            chk("row_sb_empty", sb.size(), 0);
        end

        cfg(16'h1000, 4'd2, 2'd1);
        for (int k = 1; k <= 20; k++) sb.push_back(k <= 16 ? smp(2'd1, 4'd2, k - 1, 16'h1000) : smp(2'd2, 4'd8, k - 1, 16'h1000));
        i_rate_div = '0; i_ready = 1'b1; i_en = 1'b1;
        clk1();
        for (int k = 1; k <= 20; k++) begin
            clk1();
            chk("mid_sel", o_sel, k < 16 ? 2 : 8);
            chk("mid_wrap", o_wrap, k == 16);
            chk("mid_cfg_ready", o_cfg_ready, (k < 4) || (k == 16));
            if (k == 3) begin
                i_cfg_valid = 1'b1; i_cfg_step = 16'h1000; i_cfg_sel = 4'd8; i_cfg_wave = 2'd2;
            end
            if (k == 4) begin
                i_cfg_step = 16'h2000; i_cfg_sel = 4'd9; i_cfg_wave = 2'd3;
            end
            if (k == 17) i_cfg_valid = 1'b0;
        end
        i_en = 1'b0;
        clk1();
        chk("stop_sel_held", o_sel, 8);
        clk1();
        chk("idle_apply_sel", o_sel, 9);
        chk("idle_apply_wave", o_wave, 3);
        chk("idle_apply_ready", o_cfg_ready, 1);
        chk("mid_sb_empty", sb.size(), 0);

        cfg(16'h0400, 4'd3, 2'd0);
        sb.push_back(smp(2'd0, 4'd3, 0, 16'h0400));
        i_ready = 1'b0; i_rate_div = '0; i_en = 1'b1;
        clk1();
        repeat (10) clk1();
        chk("ovr_addr", o_addr, 160);
        chk("ovr_valid", o_valid, 1);
        chk("ovr_data", $unsigned(o_data), 16'h0c00);
        chk("ovr_flag", o_overrun, 1);
`ifdef WAVEGEN_OVERRUN_CNT_EN
        chk("ovr_cnt", o_overrun_cnt, 9);
`endif
        i_en = 1'b0;
        clk1();
        chk("dis_addr", o_addr, 0);
        chk("dis_valid_held", o_valid, 1);
        repeat (3) clk1();
        chk("dis_valid_still", o_valid, 1);
        i_ready = 1'b1;
        clk1();
        chk("dis_valid_clr", o_valid, 0);
        repeat (5) clk1();
        chk("dis_no_tick", o_valid, 0);
        chk("dis_addr_idle", o_addr, 0);
        chk("ovr_sticky", o_overrun, 1);
        chk("ovr_sb_empty", sb.size(), 0);

        cfg(16'h0400, 4'd4, 2'd1);
        for (int k = 0; k < 4; k++) sb.push_back(smp(2'd1, 4'd4, k, 16'h0400));
        i_ready = 1'b1; i_rate_div = '0; i_en = 1'b1;
        clk1();
        for (int k = 1; k <= 5; k++) begin
            clk1();
            if (k == 2) begin
                i_cfg_valid = 1'b1; i_cfg_step = 16'h0800; i_cfg_sel = 4'd7; i_cfg_wave = 2'd2;
            end
            if (k == 3) i_cfg_valid = 1'b0;
        end
        chk("pre_rst_pending", o_cfg_ready, 0);
        chk("pre_rst_addr", o_addr, 80);
        i_rst = 1'b1;
        clk1();
        chk("mrst_addr", o_addr, 0);
        chk("mrst_sel", o_sel, 0);
        chk("mrst_wave", o_wave, 0);
        chk("mrst_data", $unsigned(o_data), 0);
        chk("mrst_valid", o_valid, 0);
        chk("mrst_wrap", o_wrap, 0);
        chk("mrst_overrun", o_overrun, 0);
        chk("mrst_cfg_ready", o_cfg_ready, 1);
`ifdef WAVEGEN_OVERRUN_CNT_EN
        chk("mrst_cnt", o_overrun_cnt, 0);
`endif
        i_rst = 1'b0; i_en = 1'b0;
        clk1();
        clk1();
        chk("discard_sel", o_sel, 0);
        chk("discard_wave", o_wave, 0);
        chk("discard_valid", o_valid, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
